// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and synchroniser depth for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA_RD,
    ST_DATA_SR,
    ST_DATA_ID,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the SPI pins into the aclk domain and derives SCK / CS_n edge strobes.
module spi_pin_sync
  import spi_flash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
  end

  // Idle bus levels on reset so no spurious SCK edge appears afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
  assign cs_fall  = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
  assign cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// Single-lane SPI flash target answering READ, RDSR and RDID from a byte-wide
// synchronous memory port.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_AW     = 16,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int                SETTLE_CYC = SYNC_STAGES + 1;
  localparam logic [MEM_AW-1:0] ADDR_ONE   = MEM_AW'(1);

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  spi_pin_sync u_sync (
    .clk      (aclk),
    .rst      (areset),
    .sck      (spi_sck),
    .cs_n     (spi_cs_n),
    .mosi     (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  state_t              state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [22:0]         sh_in_q, sh_in_d;
  logic [7:0]          sh_out_q, sh_out_d;
  logic [2:0]          out_cnt_q, out_cnt_d;
  logic [1:0]          id_idx_q, id_idx_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                mem_req_q, mem_req_d;
  logic                fetch_q, fetch_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;
  logic [1:0]          settle_q, settle_d;
  logic [7:0]          opcode;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

  assign opcode = {sh_in_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_in_d   = sh_in_q;
    sh_out_d  = sh_out_q;
    out_cnt_d = out_cnt_q;
    id_idx_d  = id_idx_q;
    addr_d    = addr_q;
    mem_req_d = 1'b0;
    fetch_d   = mem_req_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    settle_d  = (settle_q != 2'd0) ? settle_q - 2'd1 : settle_q;

    if (fetch_q) sh_out_d = mem_rdata;

    if (cs_rise) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      fetch_d   = 1'b0;
    end else begin
      case (state_q)
        // A CS_n fall while the synchroniser is still settling is the
        // reset-release artefact of a frame already in progress.
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = (settle_q != 2'd0) ? ST_IGNORE : ST_CMD;
            bit_cnt_d = 5'd7;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            sh_in_d = {sh_in_q[21:0], mosi_s};
            if (bit_cnt_q == 5'd0) begin
              out_cnt_d = 3'd0;
              case (opcode)
                CMD_READ: begin
                  state_d   = ST_ADDR;
                  bit_cnt_d = 5'd23;
                end
                CMD_RDSR: begin
                  state_d  = ST_DATA_SR;
                  sh_out_d = STATUS_VAL;
                end
                CMD_RDID: begin
                  state_d  = ST_DATA_ID;
                  sh_out_d = id_byte(2'd0);
                  id_idx_d = 2'd1;
                end
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q - 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            sh_in_d = {sh_in_q[21:0], mosi_s};
            if (bit_cnt_q == 5'd0) begin
              addr_d    = MEM_AW'({sh_in_q, mosi_s});
              mem_req_d = 1'b1;
              out_cnt_d = 3'd0;
              state_d   = ST_DATA_RD;
            end else begin
              bit_cnt_d = bit_cnt_q - 5'd1;
            end
          end
        end
        // Bit 0 going out is the cue to stage the next byte before the next fall.
        ST_DATA_RD, ST_DATA_SR, ST_DATA_ID: begin
          if (sck_fall) begin
            miso_d    = sh_out_q[7];
            miso_oe_d = 1'b1;
            sh_out_d  = {sh_out_q[6:0], 1'b0};
            out_cnt_d = out_cnt_q + 3'd1;
            if (out_cnt_q == 3'd7) begin
              case (state_q)
                ST_DATA_RD: begin
                  addr_d    = addr_q + ADDR_ONE;
                  mem_req_d = 1'b1;
                end
                ST_DATA_SR: sh_out_d = STATUS_VAL;
                ST_DATA_ID: begin
                  sh_out_d = id_byte(id_idx_q);
                  id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                end
                default: ;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 5'd0;
      out_cnt_q <= 3'd0;
      id_idx_q  <= 2'd0;
      addr_q    <= '0;
      mem_req_q <= 1'b0;
      fetch_q   <= 1'b0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      settle_q  <= 2'(SETTLE_CYC);
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      out_cnt_q <= out_cnt_d;
      id_idx_q  <= id_idx_d;
      addr_q    <= addr_d;
      mem_req_q <= mem_req_d;
      fetch_q   <= fetch_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      settle_q  <= settle_d;
    end
  end

  always_ff @(posedge aclk) begin
    sh_in_q  <= sh_in_d;
    sh_out_q <= sh_out_d;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
